fetch_seq: RTL
==============

Name: fetch_seq

Overview:
- Sequences instruction fetch for the MIPS core.
- Owns the architectural word-PC register and issues word-address requests to instruction memory, one outstanding at a time.
- Hands fetched instructions to decode through a valid/ready handshake.
- Redirect targets come from the next-PC logic (jump/branch); a redirect discards any in-flight fetch.
- A watchdog re-issues a fetch whose response never arrives.

Parameters:
- RESET_PC, 30'h00000C00, word address loaded on reset (byte address 0x00003000).
- MAX_WAIT, 16, cycles to wait for imem_rvalid after grant before re-issuing; legal range 2..255.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- imem_req  output  1  fetch request valid.
- imem_addr  output  30  word address of the request.
- imem_gnt  input  1  memory accepts the request this cycle (handshake completes when imem_req && imem_gnt).
- imem_rvalid  input  1  response data valid.
- imem_rdata  input  32  response instruction word.
- inst_valid  output  1  instruction presented to decode.
- inst  output  32  instruction word.
- inst_pc  output  30  word PC of inst.
- dec_ready  input  1  decode accepts inst this cycle.
- redirect  input  1  one-cycle pulse: change fetch stream.
- redirect_pc  input  30  new word PC; sampled when redirect=1.
- timeout_err  output  1  one-cycle pulse when the watchdog fires.

Behaviour:

Reset (synchronous):
- pc=RESET_PC, state=REQ.
- imem_req=0, inst_valid=0, inst=0, inst_pc=0, timeout_err=0, wait counter=0.
- The first request appears the cycle after reset deasserts.
- Reset asserted mid-operation abandons everything. Any later imem_rvalid for the old request is ignored until a new grant occurs.

States:
- REQ:
  - imem_req=1, imem_addr=pc.
  - On gnt: go to WAIT and clear the counter.
  - imem_addr stays stable while waiting for gnt.
- WAIT:
  - imem_req=0; counter increments each cycle.
  - On rvalid: latch inst=imem_rdata and inst_pc=pc, set inst_valid=1, go to HOLD.
  - If the counter reaches MAX_WAIT-1 without rvalid: pulse timeout_err for 1 cycle, go to DROP, and re-issue later.
- HOLD:
  - inst_valid=1; inst and inst_pc stay stable until the handshake.
  - On dec_ready: pc=pc+1, and go to REQ in the same edge with inst_valid=0. The next request appears the following cycle.
  - Throughput is therefore at most one instruction per 3 cycles with 1-cycle memory.
- DROP:
  - imem_req=0; waits for the stale rvalid or MAX_WAIT more cycles, then goes to REQ.
  - rdata received in DROP is discarded, never presented.

Redirect (highest priority after reset, accepted in any state):
- pc=redirect_pc, inst_valid=0 next cycle.
- From REQ: if gnt occurs in the same cycle, go to DROP; else go to REQ with the new address.
- From WAIT: go to DROP; the stale response is discarded.
- From HOLD: the held instruction is dropped even if dec_ready=1 in that cycle, go to REQ.
- From DROP: stay in DROP with the updated pc.

Arithmetic and timing rules:
- pc+1 wraps modulo 2^30 (3FFFFFFF -> 0).
- redirect_pc is used verbatim; no alignment check.
- rvalid outside WAIT/DROP is ignored.
- Only one outstanding request ever; imem_req is never asserted in WAIT or DROP.
- timeout_err is a single-cycle pulse.

Test Plan:
- Reset, gnt and rvalid tied high one cycle after req, dec_ready=1 → imem_addr sequence 0xC00, 0xC01, 0xC02; inst_pc matches, inst equals rdata.
- dec_ready held 0 for 5 cycles in HOLD → inst_valid, inst and inst_pc stable, no new imem_req; on release pc advances by exactly 1.
- redirect to 0x0000100 while in WAIT; stale rvalid with rdata=0xDEADBEEF arrives → never presented; next imem_addr=0x0000100.
- redirect coincident with dec_ready in HOLD → instruction dropped; next request address=redirect_pc, not inst_pc+1.
- No rvalid for MAX_WAIT=16 cycles → timeout_err pulses once at the 16th WAIT cycle; request for the same address re-issued after DROP.
- pc=0x3FFFFFFF handed off → next imem_addr=0x00000000; reset asserted during WAIT → next req at 0xC00, and a late rvalid is ignored.

Source files
------------

// File: rtl/fetch_seq.sv
// fetch_seq: instruction fetch sequencer for the MIPS core.
// Owns the word PC. It issues one word-address request at a time to
// instruction memory and hands each fetched word to decode over valid/ready.
// Redirects from the next-PC logic discard any fetch still in flight.
// A watchdog re-issues a fetch whose response never arrives.
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   imem_req/imem_addr/imem_gnt   request channel (word address)
//   imem_rvalid/imem_rdata        response channel
//   inst_valid/inst/inst_pc       instruction to decode
//   dec_ready                     decode accepts inst
//   redirect/redirect_pc          change of fetch stream (one-cycle pulse)
//   timeout_err                   one-cycle pulse when the watchdog fires
module fetch_seq #(
  parameter logic [29:0] RESET_PC = 30'h00000C00,
  parameter int unsigned MAX_WAIT = 16
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [29:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [29:0] inst_pc,
  input  logic        dec_ready,
  input  logic        redirect,
  input  logic [29:0] redirect_pc,
  output logic        timeout_err
);

  localparam int unsigned PC_W   = 30;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2,
    S_DROP = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                req_q, req_d;
  logic                inst_valid_q, inst_valid_d;
  logic [DATA_W-1:0]   inst_q, inst_d;
  logic [PC_W-1:0]     inst_pc_q, inst_pc_d;
  logic                timeout_q, timeout_d;
  logic                granted;

  // A grant only counts while the registered request is actually on the bus.
  assign granted = (state_q == S_REQ) && req_q && imem_gnt;

  // Next-state and output computation.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    cnt_d        = cnt_q;
    inst_valid_d = inst_valid_q;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    timeout_d    = 1'b0;

    if (redirect) begin
      pc_d         = redirect_pc;
      inst_valid_d = 1'b0;
      case (state_q)
        S_REQ: begin
          // A request granted alongside the redirect is already in flight.
          if (granted) begin
            state_d = S_DROP;
            cnt_d   = '0;
          end
        end
        S_WAIT: begin
          state_d = S_DROP;
          cnt_d   = '0;
        end
        S_HOLD:  state_d = S_REQ;
        S_DROP:  cnt_d   = '0;
        default: state_d = S_REQ;
      endcase
    end else begin
      case (state_q)
        S_REQ: begin
          if (granted) begin
            state_d = S_WAIT;
            cnt_d   = '0;
          end
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            inst_d       = imem_rdata;
            inst_pc_d    = pc_q;
            inst_valid_d = 1'b1;
            state_d      = S_HOLD;
          end else if (cnt_q == CNT_LAST) begin
            timeout_d = 1'b1;
            state_d   = S_DROP;
            cnt_d     = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_HOLD: begin
          if (dec_ready) begin
            pc_d         = pc_q + PC_W'(1);
            inst_valid_d = 1'b0;
            state_d      = S_REQ;
          end
        end
        S_DROP: begin
          // Drain the outstanding response, or give up after MAX_WAIT cycles.
          if (imem_rvalid || (cnt_q == CNT_LAST)) begin
            state_d = S_REQ;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: state_d = S_REQ;
      endcase
    end

    req_d = (state_d == S_REQ);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_REQ;
      pc_q         <= RESET_PC;
      cnt_q        <= '0;
      req_q        <= 1'b0;
      inst_valid_q <= 1'b0;
      inst_q       <= '0;
      inst_pc_q    <= '0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      cnt_q        <= cnt_d;
      req_q        <= req_d;
      inst_valid_q <= inst_valid_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      timeout_q    <= timeout_d;
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign inst_valid  = inst_valid_q;
  assign inst        = inst_q;
  assign inst_pc     = inst_pc_q;
  assign timeout_err = timeout_q;

endmodule
